// File: rtl/ysyx_22040895_idu_pkg.sv
// Shared decode-stage types: instruction format codes, RV opcodes and immediate widths.
package ysyx_22040895_idu_pkg;

  localparam int unsigned RV_INST_W = 32;
  localparam int unsigned OPC_W     = 7;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned IMM1_W    = 12;
  localparam int unsigned IMM2_W    = 20;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  localparam logic [OPC_W-1:0] OPC_LOAD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OPC_JALR    = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM  = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_STORE   = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI     = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL     = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP      = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP32    = 7'b0111011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } idu_state_e;

  typedef struct packed {
    logic [IMM1_W-1:0] imm1;
    logic [IMM2_W-1:0] imm2;
    logic              immsel;
    fmt_e              fmt;
    logic              illegal;
  } imm_info_t;

endpackage

// File: rtl/ysyx_22040895_imm_extract.sv
// Raw immediate field extraction and format classification for one RV instruction.
// Pure combinational; sign extension is left to the downstream sext unit.
module ysyx_22040895_imm_extract
  import ysyx_22040895_idu_pkg::*;
(
  input  logic [RV_INST_W-1:0] i_inst,
  output imm_info_t            o_info
);

  logic [OPC_W-1:0] w_opc;

  assign w_opc = i_inst[OPC_W-1:0];

  always_comb begin
    o_info         = '0;
    o_info.immsel  = 1'b1;
    o_info.fmt     = FMT_NONE;
    o_info.illegal = 1'b0;
    case (w_opc)
      OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_SYSTEM: begin
        o_info.fmt  = FMT_I;
        o_info.imm1 = i_inst[31:20];
      end
      OPC_STORE: begin
        o_info.fmt  = FMT_S;
        o_info.imm1 = {i_inst[31:25], i_inst[11:7]};
      end
      // imm[12:1]; execute restores the implicit zero LSB
      OPC_BRANCH: begin
        o_info.fmt  = FMT_B;
        o_info.imm1 = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8]};
      end
      OPC_LUI, OPC_AUIPC: begin
        o_info.fmt    = FMT_U;
        o_info.immsel = 1'b0;
        o_info.imm2   = i_inst[31:12];
      end
      OPC_JAL: begin
        o_info.fmt    = FMT_J;
        o_info.immsel = 1'b0;
        o_info.imm2   = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21]};
      end
      OPC_OP, OPC_OP32: begin
        o_info.fmt = FMT_R;
      end
      default: begin
        o_info.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_22040895_idu.sv
// Decode-stage front end: 2-entry skid buffer (head + skid) between IFU and execute,
// with register/immediate field extraction on the head entry and flush on redirect.
module ysyx_22040895_idu
  import ysyx_22040895_idu_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned INST_W = RV_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [REG_W-1:0]  out_rs1,
  output logic [REG_W-1:0]  out_rs2,
  output logic [REG_W-1:0]  out_rd,
  output logic [IMM1_W-1:0] out_imm1,
  output logic [IMM2_W-1:0] out_imm2,
  output logic              out_immsel,
  output fmt_e              out_fmt,
  output logic              out_illegal
);

  idu_state_e        r_state;
  logic              r_in_ready;
  logic [ADDR_W-1:0] r_h_pc;
  logic [INST_W-1:0] r_h_inst;
  logic [ADDR_W-1:0] r_s_pc;
  logic [INST_W-1:0] r_s_inst;

  logic              w_h_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  imm_info_t         w_info;

  // Reset masks the handshake immediately; in_ready otherwise has no path from out_ready.
  assign w_h_valid  = (r_state != ST_EMPTY) && !rst;
  assign in_ready   = r_in_ready && !rst;
  assign out_valid  = w_h_valid;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = w_h_valid && out_ready;

  // Buffer control; payload registers are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else if (flush) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            r_state  <= ST_ONE;
            r_h_pc   <= in_pc;
            r_h_inst <= in_inst;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            r_h_pc   <= in_pc;
            r_h_inst <= in_inst;
          end else if (w_in_fire) begin
            r_state    <= ST_FULL;
            r_in_ready <= 1'b0;
            r_s_pc     <= in_pc;
            r_s_inst   <= in_inst;
          end else if (w_out_fire) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            r_state    <= ST_ONE;
            r_in_ready <= 1'b1;
            r_h_pc     <= r_s_pc;
            r_h_inst   <= r_s_inst;
          end
        end
        default: begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  ysyx_22040895_imm_extract u_imm_extract (
    .i_inst (r_h_inst),
    .o_info (w_info)
  );

  // Decoded view of the head entry, forced to zero whenever the head is empty.
  always_comb begin
    out_pc      = '0;
    out_inst    = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_rd      = '0;
    out_imm1    = '0;
    out_imm2    = '0;
    out_immsel  = 1'b0;
    out_fmt     = FMT_R;
    out_illegal = 1'b0;
    if (w_h_valid) begin
      out_pc      = r_h_pc;
      out_inst    = r_h_inst;
      out_rs1     = r_h_inst[19:15];
      out_rs2     = r_h_inst[24:20];
      out_rd      = r_h_inst[11:7];
      out_imm1    = w_info.imm1;
      out_imm2    = w_info.imm2;
      out_immsel  = w_info.immsel;
      out_fmt     = w_info.fmt;
      out_illegal = w_info.illegal;
    end
  end

endmodule

// File: tb/tb_ysyx_22040895_idu.sv
// Self-checking bench for ysyx_22040895_idu: directed decode table, buffer corner
// sequences, and a randomized run against a queue-based reference model.
module tb_ysyx_22040895_idu;
  import ysyx_22040895_idu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_pc, out_pc;
  logic [31:0] in_inst, out_inst;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [11:0] out_imm1;
  logic [19:0] out_imm2;
  logic        out_immsel, out_illegal;
  fmt_e        out_fmt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [11:0] imm1;
    logic [19:0] imm2;
    logic        immsel;
    fmt_e        fmt;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    exp_t        e;
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  always #5 clk = ~clk;

  ysyx_22040895_idu #(.ADDR_W(64), .INST_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm1(out_imm1), .out_imm2(out_imm2), .out_immsel(out_immsel),
    .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the ISA immediate definitions: build the full immediate, then slice.
  function automatic exp_t ref_dec(input logic [31:0] i);
    exp_t        e;
    logic [31:0] v;
    e = '{imm1: '0, imm2: '0, immsel: 1'b1, fmt: FMT_NONE, ill: 1'b0};
    v = '0;
    case (i[6:0])
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: begin
        v = {{20{i[31]}}, i[31:20]};
        e.fmt = FMT_I; e.imm1 = v[11:0];
      end
      7'h23: begin
        v = {{20{i[31]}}, i[31:25], i[11:7]};
        e.fmt = FMT_S; e.imm1 = v[11:0];
      end
      7'h63: begin
        v = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        e.fmt = FMT_B; e.imm1 = v[12:1];
      end
      7'h37, 7'h17: begin
        v = {i[31:12], 12'b0};
        e.fmt = FMT_U; e.imm2 = v[31:12]; e.immsel = 1'b0;
      end
      7'h6F: begin
        v = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        e.fmt = FMT_J; e.imm2 = v[20:1]; e.immsel = 1'b0;
      end
      7'h33, 7'h3B: e.fmt = FMT_R;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  task automatic check_dec(input string tag, input logic [63:0] pc, input logic [31:0] inst,
                           input exp_t e);
    chk({tag, "_valid"},   out_valid,   1'b1);
    chk({tag, "_pc"},      out_pc,      pc);
    chk({tag, "_inst"},    out_inst,    inst);
    chk({tag, "_rs1"},     out_rs1,     inst[19:15]);
    chk({tag, "_rs2"},     out_rs2,     inst[24:20]);
    chk({tag, "_rd"},      out_rd,      inst[11:7]);
    chk({tag, "_imm1"},    out_imm1,    e.imm1);
    chk({tag, "_imm2"},    out_imm2,    e.imm2);
    chk({tag, "_immsel"},  out_immsel,  e.immsel);
    chk({tag, "_fmt"},     out_fmt,     e.fmt);
    chk({tag, "_illegal"}, out_illegal, e.ill);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [14];
    ops = '{7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23, 7'h63,
            7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h00};
    return {25'($urandom), ops[$urandom_range(0, 13)]};
  endfunction

  initial begin
    vec_t        vt [7];
    ent_t        q [$];
    logic [63:0] got [$];
    logic        sent8;

    vt[0] = '{32'h00500093, '{12'h005, 20'h0,     1'b1, FMT_I,    1'b0}};
    vt[1] = '{32'hFE000EE3, '{12'hFFE, 20'h0,     1'b1, FMT_B,    1'b0}};
    vt[2] = '{32'h800002B7, '{12'h000, 20'h80000, 1'b0, FMT_U,    1'b0}};
    vt[3] = '{32'h00113423, '{12'h008, 20'h0,     1'b1, FMT_S,    1'b0}};
    vt[4] = '{32'hFFDFF06F, '{12'h000, 20'hFFFFE, 1'b0, FMT_J,    1'b0}};
    vt[5] = '{32'h002081B3, '{12'h000, 20'h0,     1'b1, FMT_R,    1'b0}};
    vt[6] = '{32'h0000007F, '{12'h000, 20'h0,     1'b1, FMT_NONE, 1'b1}};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_inst = '0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1'b1);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_rd", out_rd, 5'd0);

    // Directed decode table: one instruction at a time, 1-cycle latency
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_pc = 64'h8000_0000 + 64'(4 * k); in_inst = vt[k].inst; out_ready = 1'b1;
      @(posedge clk); #1; in_valid = 1'b0;
      @(negedge clk);
      check_dec($sformatf("tbl%0d", k), 64'h8000_0000 + 64'(4 * k), vt[k].inst, vt[k].e);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("tbl_drain_valid", out_valid, 1'b0);

    // Stream three with downstream stalled, then release
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h0; in_inst = 32'h00500093;
    @(posedge clk); #1; in_pc = 64'h4;
    @(posedge clk); #1; in_pc = 64'h8;
    @(negedge clk);
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_out_pc", out_pc, 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("full_hold_pc", out_pc, 64'h0);
    chk("full_hold_imm1", out_imm1, 12'h005);
    @(posedge clk); #1; out_ready = 1'b1;
    sent8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_pc);
      if (in_valid && in_ready) sent8 = 1'b1;
      @(posedge clk); #1;
      if (sent8) in_valid = 1'b0;
    end
    chk("order_count", 64'(got.size()), 64'd3);
    for (int k = 0; k < 3; k++)
      chk($sformatf("order_%0d", k), (k < got.size()) ? got[k] : 64'hDEAD, 64'(4 * k));

    // Flush from FULL with the IFU still offering
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 64'h100;
    @(posedge clk); #1; in_pc = 64'h104;
    @(posedge clk); #1; in_pc = 64'h108; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_full_out_valid", out_valid, 1'b0);
    chk("flush_full_in_ready", in_ready, 1'b1);

    // Flush from ONE while an input fires: that input must be dropped
    @(posedge clk); #1; in_valid = 1'b1; in_pc = 64'h200; out_ready = 1'b0;
    @(posedge clk); #1; in_pc = 64'h204; flush = 1'b1;
    @(negedge clk);
    chk("flush_one_in_ready", in_ready, 1'b1);
    @(posedge clk); #1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush_drop_valid", out_valid, 1'b0);
      @(posedge clk); #1;
    end

    // Reset mid-stream
    in_valid = 1'b1; in_pc = 64'h300; in_inst = 32'h0000007F; out_ready = 1'b0;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", out_valid, 1'b1);
    chk("pre_rst_illegal", out_illegal, 1'b1);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("after_mid_rst_valid", out_valid, 1'b0);
    chk("after_mid_rst_ready", in_ready, 1'b1);

    // Randomized traffic against a FIFO model of at most two entries
    for (int c = 0; c < 3000; c++) begin
      bit m_in, m_out;
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pc     = {$urandom, $urandom};
      in_inst   = rand_inst();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      @(negedge clk);
      chk("rnd_out_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) check_dec("rnd", q[0].pc, q[0].inst, ref_dec(q[0].inst));
      m_in  = in_valid && (q.size() < 2);
      m_out = out_ready && (q.size() > 0);
      if (flush) q.delete();
      else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back('{in_pc, in_inst});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040895_idu.md
Name: ysyx_22040895_idu

Overview:
Decode-stage front end between the instruction fetch unit (IFU) and the sign-extension/execute path.
- Accepts fetched {pc, inst} through a valid/ready handshake and buffers them in a 2-entry skid buffer.
- Extracts register indices and the raw immediate fields from the instruction.
- Drives the 12-bit/20-bit immediate plus the select bit that the downstream sign-extender consumes.
- Supports pipeline flush on redirect.

Parameters:
- ADDR_W, 64, PC width.
- INST_W, 32, instruction width; fixed RV base encoding, must be 32.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  redirect; discard all buffered instructions.
- in_valid  in  1  IFU has a valid instruction.
- in_ready  out  1  IDU can accept this cycle.
- in_pc  in  ADDR_W  PC of the incoming instruction.
- in_inst  in  INST_W  incoming instruction.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  downstream accepts this cycle.
- out_pc  out  ADDR_W  PC of the head instruction.
- out_inst  out  INST_W  raw head instruction.
- out_rs1, out_rs2, out_rd  out  5 each  register indices (inst[19:15], inst[24:20], inst[11:7]).
- out_imm1  out  12  short immediate, to sext imm1 input.
- out_imm2  out  20  long immediate, to sext imm2 input.
- out_immsel  out  1  1 = use imm1, 0 = use imm2.
- out_fmt  out  3  format code (package enum).
- out_illegal  out  1  opcode not recognised.

Behaviour:
- Storage: head register (H) and skid register (S), each holding {valid, pc, inst}. All outputs are decoded combinationally from H only.
- States:
  - EMPTY: H and S invalid.
  - ONE: H valid.
  - FULL: H and S valid.
- Handshake: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !S.valid, taken from a register, with no combinational path from out_ready.
- out_valid = H.valid.
- Transitions (when flush = 0):
  - EMPTY + in_fire -> ONE; the input loads into H.
  - ONE + in_fire + out_fire -> ONE; H reloads with the input.
  - ONE + in_fire + !out_fire -> FULL; the input loads into S.
  - ONE + out_fire + !in_fire -> EMPTY.
  - FULL + out_fire -> ONE; S moves to H and S is invalidated. in_ready is 0 in FULL, so no input can arrive in this cycle.
  - FULL + !out_fire -> hold; H and S stay stable.
- Ordering: strict FIFO. An instruction never overtakes an older one.
- Output stability: while out_valid & !out_ready, every out_* signal must hold constant.
- flush = 1:
  - Next cycle: H.valid = S.valid = 0 and in_ready = 1.
  - Any in_fire in the flush cycle is dropped.
  - out_fire in the flush cycle is still a legal handoff. Downstream is responsible for squashing it.
  - flush overrides all other transitions.
- Reset (rst = 1 at a clk edge):
  - H.valid = S.valid = 0.
  - in_ready = 1 from the first cycle after deassertion.
  - While rst is high, in_ready = 0 and out_valid = 0.
  - pc/inst payload registers are not reset.
  - Reset asserted mid-transfer behaves the same as flush, with priority over flush.
- Immediate extraction (raw, no extension):
  - I-type (opcodes 0000011, 0010011, 0011011, 1100111, 1110011): imm1 = inst[31:20], immsel = 1.
  - S-type (0100011): imm1 = {inst[31:25], inst[11:7]}, immsel = 1.
  - B-type (1100011): imm1 = {inst[31], inst[7], inst[30:25], inst[11:8]} = imm[12:1], immsel = 1. Execute applies the <<1.
  - U-type (0110111, 0010111): imm2 = inst[31:12], immsel = 0.
  - J-type (1101111): imm2 = {inst[31], inst[19:12], inst[20], inst[30:21]} = imm[20:1], immsel = 0.
  - R-type (0110011, 0111011): imm1 = imm2 = 0, immsel = 1.
  - Unknown opcode: out_illegal = 1, out_fmt = FMT_NONE, imm1 = imm2 = 0, immsel = 1.
- The unused immediate output is always driven to 0.
- When out_valid = 0, all decoded outputs are 0.
- Latency: 1 cycle from in_fire to out_valid when EMPTY. Throughput: 1 instruction per cycle when out_ready is held high.

Decomposition:
- Shared package/define file:
  - FMT_* encodings: R, I, S, B, U, J, NONE.
  - RV opcode constants.
  - Immediate length macros (12/20).
  - INST_W.
- One natural sub-module: ysyx_22040895_imm_extract. It is purely combinational, takes inst and produces {imm1, imm2, immsel, fmt, illegal}, and is instantiated on H.

Test Plan:
1. Reset, then in_inst = 0x00500093 (addi x1, x0, 5) at pc 0x80000000 with out_ready = 1.
   -> One cycle later: out_valid = 1, rd = 1, imm1 = 0x005, immsel = 1, fmt = I.
2. in_inst = 0xFE000EE3 (B-type, offset -4).
   -> imm1 = 0xFFE, immsel = 1, imm2 = 0, fmt = B.
3. in_inst = 0x800002B7 (lui x5, 0x80000).
   -> imm2 = 0x80000, immsel = 0, imm1 = 0, rd = 5.
4. Stream pc 0x0, 0x4, 0x8 with out_ready = 0.
   -> After 2 accepts, in_ready = 0 and out_pc holds 0x0.
   -> Raise out_ready: outputs appear in order 0x0, 0x4, 0x8 with no loss or duplication.
5. FULL state, then pulse flush with in_valid = 1.
   -> Next cycle: out_valid = 0, in_ready = 1, and the flush-cycle input never appears.
6. in_inst = 0x0000007F (unknown opcode).
   -> out_illegal = 1, fmt = NONE, imm1 = imm2 = 0. Also assert rst mid-stream -> out_valid = 0 on the following cycle.
